// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus the valid/ready output stream.
// master = the reader block, slave = the FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side controller for the synchronous FIFO.
// Issues reads, absorbs the FIFO's 1-cycle read latency in a 2-entry skid
// buffer and presents the words as a valid/ready stream.
// Optional macro FIFO_RD_CNT_EN adds a saturating delivered-word counter.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus,
  input  logic                 flush,
  output logic [1:0]           level
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]     word_count
`endif
);

  logic [1:0]       r_level;
  logic             r_inflight;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  logic             w_pop;
  logic             w_capture;
  logic [2:0]       w_occ;
  logic [1:0]       w_level_next;

  // A pop during flush is not counted; the buffer is discarded anyway.
  assign w_pop     = r_valid && bus.m_ready && !flush;
  assign w_capture = r_inflight && !flush;

  // Occupancy after this cycle's pop decides whether another read fits.
  always_comb begin
    w_occ        = 3'(r_level) + 3'(r_inflight) - 3'(w_pop);
    w_level_next = r_level + 2'(w_capture) - 2'(w_pop);
  end

  assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush && (w_occ < 3'd2);
  assign bus.m_valid    = r_valid;
  assign bus.m_data     = r_head;
  assign level          = r_level;

  // Skid buffer: capture returning words behind the tail, shift head on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level    <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= bus.fifo_rd_en;
      if (flush) begin
        r_level <= 2'd0;
        r_valid <= 1'b0;
      end else begin
        r_level <= w_level_next;
        r_valid <= (w_level_next != 2'd0);
        case ({w_capture, w_pop})
          2'b10: begin
            if (r_level == 2'd0) r_head <= bus.fifo_data;
            else                 r_tail <= bus.fifo_data;
          end
          2'b01: r_head <= r_tail;
          2'b11: begin
            if (r_level == 2'd1) begin
              r_head <= bus.fifo_data;
            end else begin
              r_head <= r_tail;
              r_tail <= bus.fifo_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Delivered-word counter; cleared only by reset, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_cnt <= '0;
    else if (w_pop) r_cnt <= sat_inc(r_cnt);
  end

  assign word_count = r_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: acts as the FIFO (queue with 1-cycle read
// latency) and the consumer, checking every cycle against a queue model.
module tb_fifo_stream_reader;
  localparam int WIDTH = 8;
`ifdef FIFO_RD_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] level;
`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] word_count;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();

  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .flush(flush),
    .level(level)
`ifdef FIFO_RD_CNT_EN
    ,
    .word_count(word_count)
`endif
  );

  logic [7:0] fq[$];    // FIFO contents
  logic [7:0] mq[$];    // words held by the reader
  logic [7:0] sent[$];  // words written into the FIFO this phase
  logic [7:0] recv[$];  // words accepted by the consumer this phase
  bit         infl;
  int         cnt;
  int         tests;
  int         fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    sent.push_back(w);
  endtask

  task automatic new_phase();
    sent.delete();
    recv.delete();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, recv.size(), sent.size());
    for (int i = 0; i < sent.size() && i < recv.size(); i++)
      chk({tag, "_order"}, recv[i], sent[i]);
  endtask

  // One clock cycle: drive inputs, check against model, then advance both.
  task automatic cycle(input bit rdy, input bit fl, input bit rn);
    bit pop, erd;
    bus.m_ready    = rdy;
    flush          = fl;
    rst_n          = rn;
    bus.fifo_empty = (fq.size() == 0);
    #1;
    pop = (mq.size() != 0) && rdy && !fl;
    erd = rn && (fq.size() != 0) && !fl &&
          ((int'(mq.size()) + int'(infl) - int'(pop)) < 2);
    chk("rd_en", bus.fifo_rd_en, erd);
    if (bus.fifo_empty) chk("rd_en_while_empty", bus.fifo_rd_en, 0);
    chk("m_valid", bus.m_valid, mq.size() != 0);
    if (mq.size() != 0) chk("m_data", bus.m_data, mq[0]);
    chk("level", level, mq.size());
`ifdef FIFO_RD_CNT_EN
    chk("word_count", word_count, cnt);
`endif
    @(posedge clk);
    #1;
    if (!rn) begin
      mq.delete();
      cnt = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (pop) begin
        recv.push_back(mq.pop_front());
        if (cnt < (1 << CNT_W) - 1) cnt++;
      end
      if (infl) mq.push_back(bus.fifo_data);
    end
    infl = erd;
    if (erd) bus.fifo_data = fq.pop_front();
  endtask

  initial begin
    tests = 0; fails = 0; infl = 0; cnt = 0;
    rst_n = 1'b0; flush = 1'b0;
    bus.m_ready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_data = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with the FIFO showing non-empty to prove rd_en is forced low.
    bus.fifo_empty = 1'b0;
    #1;
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_level", level, 0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_word_count", word_count, 0);
`endif
    bus.fifo_empty = 1'b1;

    // Three preloaded words, consumer always ready.
    new_phase();
    push(8'h11); push(8'h22); push(8'h33);
    repeat (8) cycle(1, 0, 1);
    check_stream("preload");

    // Backpressure: only two reads, head stable, then drain back-to-back.
    new_phase();
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    repeat (6) cycle(0, 0, 1);
    chk("bp_level", level, 2);
    chk("bp_head", bus.m_data, 8'hA0);
    chk("bp_fifo_left", fq.size(), 3);
    repeat (8) cycle(1, 0, 1);
    check_stream("bp");

    // Alternating ready over 16 words.
    new_phase();
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 44; i++) cycle(i[0] == 1'b0, 0, 1);
    check_stream("alt");

    // Flush with one word held and one in flight.
    new_phase();
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    repeat (4) cycle(0, 0, 1);
    cycle(1, 0, 1);
    cycle(0, 1, 1);
    chk("flush_m_valid", bus.m_valid, 0);
    chk("flush_level", level, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    chk("flush_resume_valid", bus.m_valid, 1);
    chk("flush_resume_data", bus.m_data, 8'hC3);
    repeat (8) cycle(1, 0, 1);

    // Reset mid-stream.
    new_phase();
    for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
    repeat (3) cycle(1, 0, 1);
    cycle(1, 0, 0);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_level", level, 0);
    repeat (10) cycle(1, 0, 1);

`ifdef FIFO_RD_CNT_EN
    // Counter saturation and flush immunity.
    new_phase();
    for (int i = 0; i < 20; i++) push(8'(i));
    repeat (25) cycle(1, 0, 1);
    chk("cnt_sat", word_count, 15);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    chk("cnt_after_flush", word_count, 15);
`endif

    // Random traffic without flush: complete ordered delivery.
    new_phase();
    for (int i = 0; i < 300; i++) begin
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) push(8'($urandom));
      cycle($urandom_range(0, 2) != 0, 0, 1);
    end
    repeat (20) cycle(1, 0, 1);
    check_stream("rand");

    // Random traffic with occasional flush and reset: cycle model only.
    for (int i = 0; i < 300; i++) begin
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) push(8'($urandom));
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) != 0);
    end
    repeat (20) cycle(1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
